// File: rtl/fpu_pipeline_stage_register.sv
// Generic FPU pipeline stage register with valid/ready handshake, optional 2-entry
// skid buffer, synchronous flush and a saturating back-pressure counter.
module fpu_pipeline_stage_register #(
  parameter int unsigned           DATA_WIDTH       = 64,
  parameter int unsigned           CTRL_WIDTH       = 16,
  parameter logic [CTRL_WIDTH-1:0] CTRL_RESET_VALUE = '0,
  parameter bit                    SKID_ENABLE      = 1'b1,
  parameter int unsigned           STALL_CNT_WIDTH  = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [DATA_WIDTH-1:0]      in_data,
  input  logic [CTRL_WIDTH-1:0]      in_ctrl,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH-1:0]      out_data,
  output logic [CTRL_WIDTH-1:0]      out_ctrl,
  output logic [1:0]                 occupancy,
  output logic [STALL_CNT_WIDTH-1:0] stall_count
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t                     state, state_nxt;
  logic                       in_xfer, out_xfer;
  logic                       load_main_in, load_main_skid, load_skid;
  logic [DATA_WIDTH-1:0]      main_data, skid_data;
  logic [CTRL_WIDTH-1:0]      main_ctrl, skid_ctrl;
  logic [STALL_CNT_WIDTH-1:0] stall_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= EMPTY;
    else          state <= state_nxt;
  end

  assign in_xfer  = in_valid && in_ready;
  assign out_xfer = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: if (in_xfer) begin
          load_main_in = 1'b1;
          state_nxt    = ONE;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            load_main_in = 1'b1;
          end else if (in_xfer && SKID_ENABLE) begin
            load_skid = 1'b1;
            state_nxt = FULL;
          end else if (out_xfer) begin
            state_nxt = EMPTY;
          end
        end
        FULL: if (out_xfer) begin
          load_main_skid = 1'b1;
          state_nxt      = ONE;
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  // Without the skid entry, in_ready must look through to out_ready to keep full throughput.
  always_comb begin
    out_valid   = (state != EMPTY);
    in_ready    = SKID_ENABLE ? (state != FULL) : ((state == EMPTY) || out_ready);
    occupancy   = state;
    out_data    = main_data;
    out_ctrl    = main_ctrl;
    stall_count = stall_cnt;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      main_ctrl <= CTRL_RESET_VALUE;
      skid_ctrl <= CTRL_RESET_VALUE;
    end else begin
      if (state_nxt == EMPTY)  main_ctrl <= CTRL_RESET_VALUE;
      else if (load_main_in)   main_ctrl <= in_ctrl;
      else if (load_main_skid) main_ctrl <= skid_ctrl;
      if (flush)               skid_ctrl <= CTRL_RESET_VALUE;
      else if (load_skid)      skid_ctrl <= in_ctrl;
    end
  end

  always_ff @(posedge clk) begin
    if (load_main_in)        main_data <= in_data;
    else if (load_main_skid) main_data <= skid_data;
    if (load_skid)           skid_data <= in_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) stall_cnt <= '0;
    else if (out_valid && !out_ready && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
  end

endmodule

// File: tb/tb_fpu_pipeline_stage_register.sv
// Randomised bench for fpu_pipeline_stage_register: three instances (skid, narrow
// stall counter, no skid) checked against queue-based reference models.
module tb_fpu_pipeline_stage_register;

  localparam int DW = 64;
  localparam int CW = 16;
  localparam logic [CW-1:0] CRV = 16'hA5C3;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  int vec = 0;
  int miss = 0;

  // skid instance
  logic a_flush = 0, a_in_valid = 0, a_in_ready, a_out_valid, a_out_ready = 0;
  logic [DW-1:0] a_in_data = '0, a_out_data;
  logic [CW-1:0] a_in_ctrl = '0, a_out_ctrl;
  logic [1:0] a_occ;
  logic [15:0] a_stall;
  // narrow stall counter instance
  logic s_flush = 0, s_in_valid = 0, s_in_ready, s_out_valid, s_out_ready = 0;
  logic [DW-1:0] s_in_data = '0, s_out_data;
  logic [CW-1:0] s_in_ctrl = '0, s_out_ctrl;
  logic [1:0] s_occ;
  logic [3:0] s_stall;
  // no-skid instance
  logic n_flush = 0, n_in_valid = 0, n_in_ready, n_out_valid, n_out_ready = 0;
  logic [DW-1:0] n_in_data = '0, n_out_data;
  logic [CW-1:0] n_in_ctrl = '0, n_out_ctrl;
  logic [1:0] n_occ;
  logic [15:0] n_stall;

  fpu_pipeline_stage_register #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CTRL_RESET_VALUE(CRV),
    .SKID_ENABLE(1'b1), .STALL_CNT_WIDTH(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .in_data(a_in_data), .in_ctrl(a_in_ctrl), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .out_data(a_out_data), .out_ctrl(a_out_ctrl), .occupancy(a_occ), .stall_count(a_stall));

  fpu_pipeline_stage_register #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CTRL_RESET_VALUE(CRV),
    .SKID_ENABLE(1'b1), .STALL_CNT_WIDTH(4)) dut_s (
    .clk(clk), .reset_n(reset_n), .flush(s_flush), .in_valid(s_in_valid), .in_ready(s_in_ready),
    .in_data(s_in_data), .in_ctrl(s_in_ctrl), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_data(s_out_data), .out_ctrl(s_out_ctrl), .occupancy(s_occ), .stall_count(s_stall));

  fpu_pipeline_stage_register #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .CTRL_RESET_VALUE(CRV),
    .SKID_ENABLE(1'b0), .STALL_CNT_WIDTH(16)) dut_n (
    .clk(clk), .reset_n(reset_n), .flush(n_flush), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .in_data(n_in_data), .in_ctrl(n_in_ctrl), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .out_data(n_out_data), .out_ctrl(n_out_ctrl), .occupancy(n_occ), .stall_count(n_stall));

  // Reference model for dut_a: a FIFO of at most two entries plus a saturating counter.
  ent_t mq[$];
  int   mstall = 0;

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom(), $urandom()};
  endfunction

  // Advance one clock for dut_a's model; inputs are stable across the edge.
  task automatic step();
    bit ov, ir;
    @(posedge clk);
    ov = (mq.size() > 0);
    ir = (mq.size() < 2);
    if (!reset_n) begin
      mq.delete();
      mstall = 0;
    end else begin
      if (ov && !a_out_ready && mstall < 65535) mstall++;
      if (a_flush) mq.delete();
      else begin
        if (ov && a_out_ready) void'(mq.pop_front());
        if (a_in_valid && ir) mq.push_back('{d: a_in_data, c: a_in_ctrl});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    vec++; if (a_out_valid !== 1'b0) begin miss++; $display("FAIL rst_out_valid got %0b exp 0", a_out_valid); end
    vec++; if (a_in_ready !== 1'b1) begin miss++; $display("FAIL rst_in_ready got %0b exp 1", a_in_ready); end
    vec++; if (a_out_ctrl !== CRV) begin miss++; $display("FAIL rst_out_ctrl got %0h exp %0h", a_out_ctrl, CRV); end
    vec++; if (a_stall !== 16'd0) begin miss++; $display("FAIL rst_stall got %0d exp 0", a_stall); end
    reset_n = 1'b1;
    mq.delete(); mstall = 0;
    a_out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1; a_in_data = rnd_data(); a_in_ctrl = CW'($urandom()); step();
    end
    a_in_valid = 0; step();
    vec++; if (a_occ !== 2'd2) begin miss++; $display("FAIL pre_rst_occ got %0d exp 2", a_occ); end
    #2 reset_n = 1'b0;
    #1;
    vec++; if (a_out_valid !== 1'b0) begin miss++; $display("FAIL async_rst_out_valid got %0b exp 0", a_out_valid); end
    vec++; if (a_in_ready !== 1'b1) begin miss++; $display("FAIL async_rst_in_ready got %0b exp 1", a_in_ready); end
    vec++; if (a_occ !== 2'd0) begin miss++; $display("FAIL async_rst_occ got %0d exp 0", a_occ); end
    vec++; if (a_out_ctrl !== CRV) begin miss++; $display("FAIL async_rst_ctrl got %0h exp %0h", a_out_ctrl, CRV); end
    vec++; if (a_stall !== 16'd0) begin miss++; $display("FAIL async_rst_stall got %0d exp 0", a_stall); end
    mq.delete(); mstall = 0;
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_stream();
    logic [DW-1:0] d[8];
    logic [CW-1:0] c[8];
    a_out_ready = 1;
    for (int i = 0; i < 8; i++) begin
      d[i] = rnd_data(); c[i] = CW'($urandom());
      a_in_valid = 1; a_in_data = d[i]; a_in_ctrl = c[i];
      step();
      vec++; if (a_out_valid !== 1'b1 || a_out_data !== d[i] || a_out_ctrl !== c[i]) begin
        miss++; $display("FAIL stream_%0d got v=%0b %0h/%0h exp v=1 %0h/%0h", i, a_out_valid, a_out_data, a_out_ctrl, d[i], c[i]);
      end
      vec++; if (a_occ !== 2'd1) begin miss++; $display("FAIL stream_occ_%0d got %0d exp 1", i, a_occ); end
    end
    a_in_valid = 0; step();
    vec++; if (a_out_valid !== 1'b0 || a_out_ctrl !== CRV) begin
      miss++; $display("FAIL stream_drain got v=%0b c=%0h exp v=0 c=%0h", a_out_valid, a_out_ctrl, CRV);
    end
  endtask

  task automatic test_skid_backpressure();
    logic [DW-1:0] d0, d1;
    int base;
    base = mstall;
    d0 = rnd_data(); d1 = rnd_data();
    a_out_ready = 0;
    a_in_valid = 1; a_in_data = d0; a_in_ctrl = 16'h0001; step();
    a_in_data = d1; a_in_ctrl = 16'h0002; step();
    a_in_valid = 0; a_in_data = rnd_data();
    for (int k = 0; k < 3; k++) begin
      vec++; if (a_occ !== 2'd2 || a_in_ready !== 1'b0 || a_out_data !== d0 || a_out_ctrl !== 16'h0001) begin
        miss++; $display("FAIL skid_hold_%0d got occ=%0d rdy=%0b %0h exp occ=2 rdy=0 %0h", k, a_occ, a_in_ready, a_out_data, d0);
      end
      step();
    end
    a_out_ready = 1;
    vec++; if (a_out_data !== d0) begin miss++; $display("FAIL skid_first got %0h exp %0h", a_out_data, d0); end
    step();
    vec++; if (a_out_valid !== 1'b1 || a_out_data !== d1 || a_out_ctrl !== 16'h0002 || a_occ !== 2'd1) begin
      miss++; $display("FAIL skid_second got v=%0b %0h occ=%0d exp v=1 %0h occ=1", a_out_valid, a_out_data, a_occ, d1);
    end
    step();
    vec++; if (a_out_valid !== 1'b0) begin miss++; $display("FAIL skid_drain got %0b exp 0", a_out_valid); end
    // Blocked cycles: the edges at which the stage held data with out_ready low.
    vec++; if (a_stall !== 16'(base + 4)) begin miss++; $display("FAIL skid_stall got %0d exp %0d", a_stall, base + 4); end
  endtask

  task automatic test_flush();
    logic [DW-1:0] d10;
    a_out_ready = 0;
    for (int i = 0; i < 2; i++) begin
      a_in_valid = 1; a_in_data = rnd_data(); a_in_ctrl = 16'h1234; step();
    end
    a_flush = 1; a_in_valid = 1; a_in_data = 64'hD9D9_D9D9_D9D9_D9D9; step();
    a_flush = 0; a_in_valid = 0;
    vec++; if (a_out_valid !== 1'b0 || a_occ !== 2'd0 || a_out_ctrl !== CRV || a_in_ready !== 1'b1) begin
      miss++; $display("FAIL flush_full got v=%0b occ=%0d c=%0h rdy=%0b exp 0/0/%0h/1", a_out_valid, a_occ, a_out_ctrl, a_in_ready, CRV);
    end
    vec++; if (a_stall !== 16'(mstall) || mstall == 0) begin miss++; $display("FAIL flush_keeps_stall got %0d exp %0d", a_stall, mstall); end
    a_out_ready = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      vec++; if (a_out_valid !== 1'b0) begin miss++; $display("FAIL flush_d9_emitted got %0h", a_out_data); end
    end
    a_flush = 1; step(); a_flush = 0;
    vec++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
      miss++; $display("FAIL flush_empty got v=%0b rdy=%0b exp 0/1", a_out_valid, a_in_ready);
    end
    d10 = rnd_data();
    a_out_ready = 0; a_in_valid = 1; a_in_data = d10; a_in_ctrl = 16'h0010; step(); a_in_valid = 0;
    vec++; if (a_out_valid !== 1'b1 || a_out_data !== d10) begin
      miss++; $display("FAIL flush_reload got v=%0b %0h exp v=1 %0h", a_out_valid, a_out_data, d10);
    end
    a_out_ready = 1; step();
  endtask

  task automatic test_random_skid();
    for (int i = 0; i < 3000; i++) begin
      a_in_valid = ($urandom_range(0, 3) != 0);
      a_out_ready = ($urandom_range(0, 2) != 0);
      a_flush = ($urandom_range(0, 99) == 0);
      a_in_data = rnd_data(); a_in_ctrl = CW'($urandom());
      #1;
      vec++; if (a_in_ready !== (mq.size() < 2)) begin miss++; $display("FAIL rnd_a_in_ready cyc %0d got %0b exp %0b", i, a_in_ready, mq.size() < 2); end
      vec++; if (a_occ !== 2'(mq.size())) begin miss++; $display("FAIL rnd_a_occ cyc %0d got %0d exp %0d", i, a_occ, mq.size()); end
      vec++; if (a_out_valid !== (mq.size() > 0)) begin miss++; $display("FAIL rnd_a_valid cyc %0d got %0b", i, a_out_valid); end
      vec++;
      if (mq.size() > 0) begin
        if (a_out_data !== mq[0].d || a_out_ctrl !== mq[0].c) begin
          miss++; $display("FAIL rnd_a_head cyc %0d got %0h/%0h exp %0h/%0h", i, a_out_data, a_out_ctrl, mq[0].d, mq[0].c);
        end
      end else if (a_out_ctrl !== CRV) begin
        miss++; $display("FAIL rnd_a_idle_ctrl cyc %0d got %0h exp %0h", i, a_out_ctrl, CRV);
      end
      vec++; if (a_stall !== 16'(mstall)) begin miss++; $display("FAIL rnd_a_stall cyc %0d got %0d exp %0d", i, a_stall, mstall); end
      step();
    end
    a_flush = 1; a_in_valid = 0; step(); a_flush = 0;
  endtask

  task automatic test_stall_saturate();
    int exp_cnt;
    s_out_ready = 0;
    s_in_valid = 1; s_in_data = rnd_data(); s_in_ctrl = 16'h0042; step();
    s_in_valid = 0;
    vec++; if (s_out_valid !== 1'b1 || s_stall !== 4'd0) begin miss++; $display("FAIL sat_load got v=%0b cnt=%0d exp 1/0", s_out_valid, s_stall); end
    for (int k = 1; k <= 23; k++) begin
      step();
      exp_cnt = (k > 15) ? 15 : k;
      vec++; if (s_stall !== 4'(exp_cnt)) begin miss++; $display("FAIL sat_cnt_%0d got %0d exp %0d", k, s_stall, exp_cnt); end
    end
    s_out_ready = 1; step();
    vec++; if (s_out_valid !== 1'b0 || s_stall !== 4'd15) begin miss++; $display("FAIL sat_release got v=%0b cnt=%0d exp 0/15", s_out_valid, s_stall); end
  endtask

  task automatic test_no_skid_random();
    ent_t nq[$];
    bit ov, ir;
    for (int i = 0; i < 10000; i++) begin
      n_in_valid = ($urandom_range(0, 3) != 0);
      n_out_ready = $urandom_range(0, 1);
      n_flush = ($urandom_range(0, 127) == 0);
      n_in_data = rnd_data(); n_in_ctrl = CW'($urandom());
      #1;
      ov = (nq.size() > 0);
      ir = (nq.size() == 0) || n_out_ready;
      vec++; if (n_in_ready !== ir) begin miss++; $display("FAIL rnd_n_in_ready cyc %0d got %0b exp %0b", i, n_in_ready, ir); end
      vec++; if (n_out_valid !== ov || n_occ !== 2'(nq.size())) begin
        miss++; $display("FAIL rnd_n_state cyc %0d got v=%0b occ=%0d exp v=%0b occ=%0d", i, n_out_valid, n_occ, ov, nq.size());
      end
      if (ov) begin
        vec++; if (n_out_data !== nq[0].d || n_out_ctrl !== nq[0].c) begin
          miss++; $display("FAIL rnd_n_order cyc %0d got %0h exp %0h", i, n_out_data, nq[0].d);
        end
      end
      @(posedge clk);
      if (n_flush) nq.delete();
      else begin
        if (ov && n_out_ready) void'(nq.pop_front());
        if (n_in_valid && ir) nq.push_back('{d: n_in_data, c: n_in_ctrl});
      end
      @(negedge clk);
    end
    n_in_valid = 0; n_flush = 0;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_skid_backpressure();
    test_flush();
    test_random_skid();
    test_stall_saturate();
    test_no_skid_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
